// File: rtl/riscv_i_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_i_pkg
//  Description : Shared constants for the I-type decode stage (opcodes,
//                instruction class codes, decoded-entry layout width).
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_i_pkg;

    // Major opcodes accepted by the I-type decode stage
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Instruction class codes presented to execute
    localparam logic [1:0] CLS_ALU  = 2'd0;
    localparam logic [1:0] CLS_LOAD = 2'd1;
    localparam logic [1:0] CLS_JALR = 2'd2;
    localparam logic [1:0] CLS_ILL  = 2'd3;

    // Decoded entry = rd(5) + rs1(5) + funct3(3) + shamt(5) + class(2) + imm(XLEN)
    localparam int ENTRY_FIXED_W = 20;

endpackage : riscv_i_pkg
`default_nettype wire

// File: rtl/i_field_decode.sv
`default_nettype none
// ============================================================================
//  Module      : i_field_decode
//  Description : Combinational I-type field extraction, immediate sign
//                extension and legality classification.
//  Revision    : 1.0 - initial release
// ============================================================================
module i_field_decode
    import riscv_i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output logic [4:0]      o_rd,
    output logic [4:0]      o_rs1,
    output logic [2:0]      o_funct3,
    output logic [XLEN-1:0] o_imm,
    output logic [4:0]      o_shamt,
    output logic [1:0]      o_cls
);

    logic [6:0] w_opcode;
    logic [6:0] w_funct7;

    assign w_opcode = i_instr[6:0];
    assign w_funct7 = i_instr[31:25];
    assign o_rd     = i_instr[11:7];
    assign o_rs1    = i_instr[19:15];
    assign o_funct3 = i_instr[14:12];
    assign o_imm    = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};

    // Classify the word; shift amount is only meaningful for OP-IMM shifts
    always_comb begin
        o_cls   = CLS_ILL;
        o_shamt = 5'd0;
        case (w_opcode)
            OPC_OP_IMM: begin
                o_cls = CLS_ALU;
                if (o_funct3 == 3'b001) begin
                    o_shamt = i_instr[24:20];
                    if (w_funct7 != 7'b0000000) begin
                        o_cls = CLS_ILL;
                    end
                end else if (o_funct3 == 3'b101) begin
                    o_shamt = i_instr[24:20];
                    if ((w_funct7 != 7'b0000000) && (w_funct7 != 7'b0100000)) begin
                        o_cls = CLS_ILL;
                    end
                end
            end
            OPC_LOAD: begin
                case (o_funct3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: o_cls = CLS_LOAD;
                    default:                                o_cls = CLS_ILL;
                endcase
            end
            OPC_JALR: begin
                if (o_funct3 == 3'b000) begin
                    o_cls = CLS_JALR;
                end
            end
            default: o_cls = CLS_ILL;
        endcase
    end

endmodule : i_field_decode
`default_nettype wire

// File: rtl/i_type_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : i_type_decode_stage
//  Description : Decodes I-type instructions into a 2-entry in-order skid
//                buffer with valid/ready on both sides, flush and a
//                load-use interlock in front of execute.
//  Revision    : 1.0 - initial release
// ============================================================================
module i_type_decode_stage
    import riscv_i_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int LU_STALL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [2:0]      out_funct3,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_shamt,
    output logic [1:0]      out_class,
    output logic            out_illegal
);

    localparam int         c_ENTRY_W  = ENTRY_FIXED_W + XLEN;
    localparam logic [1:0] c_LU_STALL = 2'(LU_STALL);

    // Occupancy states
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic [c_ENTRY_W-1:0] r_slot0;      // head entry
    logic [c_ENTRY_W-1:0] r_slot1;      // second entry, valid only when FULL
    logic                 r_in_ready;
    logic [1:0]           r_lu_cnt;
    logic [4:0]           r_last_load_rd;

    logic [4:0]           w_dec_rd;
    logic [4:0]           w_dec_rs1;
    logic [2:0]           w_dec_funct3;
    logic [XLEN-1:0]      w_dec_imm;
    logic [4:0]           w_dec_shamt;
    logic [1:0]           w_dec_cls;
    logic [c_ENTRY_W-1:0] w_dec_entry;

    logic [4:0]           w_head_rd;
    logic [4:0]           w_head_rs1;
    logic [1:0]           w_head_cls;
    logic                 w_stall;
    logic                 w_out_valid;
    logic                 w_accept;
    logic                 w_pop;

    i_field_decode #(
        .XLEN (XLEN)
    ) u_field_decode (
        .i_instr  (in_instr),
        .o_rd     (w_dec_rd),
        .o_rs1    (w_dec_rs1),
        .o_funct3 (w_dec_funct3),
        .o_imm    (w_dec_imm),
        .o_shamt  (w_dec_shamt),
        .o_cls    (w_dec_cls)
    );

    // Entry layout: {rd, rs1, funct3, shamt, class, imm}
    assign w_dec_entry = {w_dec_rd, w_dec_rs1, w_dec_funct3, w_dec_shamt, w_dec_cls, w_dec_imm};

    assign w_head_rd  = r_slot0[XLEN+19:XLEN+15];
    assign w_head_rs1 = r_slot0[XLEN+14:XLEN+10];
    assign w_head_cls = r_slot0[XLEN+1:XLEN];

    // A head reading a register still being loaded is held back from execute
    assign w_stall     = (r_lu_cnt != 2'd0) && (r_last_load_rd != 5'd0) &&
                         (w_head_rs1 == r_last_load_rd);
    assign w_out_valid = (r_state != ST_EMPTY) && !w_stall;
    assign w_accept    = in_valid && r_in_ready && !flush;
    assign w_pop       = w_out_valid && out_ready && !flush;

    assign in_ready    = r_in_ready;
    assign out_valid   = w_out_valid;
    assign out_rd      = w_head_rd;
    assign out_rs1     = w_head_rs1;
    assign out_funct3  = r_slot0[XLEN+9:XLEN+7];
    assign out_shamt   = r_slot0[XLEN+6:XLEN+2];
    assign out_class   = w_head_cls;
    assign out_imm     = r_slot0[XLEN-1:0];
    assign out_illegal = (w_head_cls == CLS_ILL);

    // Next occupancy; flush overrides any handshake in the same cycle
    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_accept) w_next_state = ST_ONE;
                ST_ONE: begin
                    if (w_accept && !w_pop)      w_next_state = ST_FULL;
                    else if (!w_accept && w_pop) w_next_state = ST_EMPTY;
                end
                ST_FULL:  if (w_pop && !w_accept) w_next_state = ST_ONE;
                default:  w_next_state = ST_EMPTY;
            endcase
        end
    end

    // Occupancy state and registered in_ready (low only when next is FULL)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != ST_FULL);
        end
    end

    // Entry storage: slot0 is always the head, slot1 shifts up on pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot0 <= '0;
            r_slot1 <= '0;
        end else if (!flush) begin
            case (r_state)
                ST_EMPTY: if (w_accept) r_slot0 <= w_dec_entry;
                ST_ONE: begin
                    if (w_accept) begin
                        if (w_pop) r_slot0 <= w_dec_entry;
                        else       r_slot1 <= w_dec_entry;
                    end
                end
                ST_FULL:  if (w_pop) r_slot0 <= r_slot1;
                default:  ;
            endcase
        end
    end

    // Load-use interlock: arm on a LOAD leaving the stage, then count down
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lu_cnt       <= 2'd0;
            r_last_load_rd <= 5'd0;
        end else if (flush) begin
            r_lu_cnt <= 2'd0;
        end else if (w_pop && (w_head_cls == CLS_LOAD)) begin
            r_lu_cnt       <= c_LU_STALL;
            r_last_load_rd <= w_head_rd;
        end else if (r_lu_cnt != 2'd0) begin
            r_lu_cnt <= r_lu_cnt - 2'd1;
        end
    end

endmodule : i_type_decode_stage
`default_nettype wire

// File: tb/tb_i_type_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i_type_decode_stage
//  Description : Self-checking bench for i_type_decode_stage with a
//                queue-based reference model and directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i_type_decode_stage;

    localparam int XLEN = 32;
    localparam int LU   = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [2:0]      out_funct3;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_shamt;
    logic [1:0]      out_class;
    logic            out_illegal;

    int n_tests = 0;
    int n_fail  = 0;

    i_type_decode_stage #(.XLEN(XLEN), .LU_STALL(LU)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_funct3  (out_funct3),
        .out_imm     (out_imm),
        .out_shamt   (out_shamt),
        .out_class   (out_class),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic [1:0]  cls;
    } ent_t;

    // Reference decode written straight from the instruction-set rules
    function automatic ent_t mdec(input logic [31:0] w);
        ent_t e;
        int   opc;
        int   f3;
        int   f7;
        bit   legal;
        opc     = int'(w[6:0]);
        f3      = int'(w[14:12]);
        f7      = int'(w[31:25]);
        e.rd    = w[11:7];
        e.rs1   = w[19:15];
        e.f3    = w[14:12];
        e.imm   = 32'($signed(w) >>> 20);
        e.shamt = (opc == 'h13 && (f3 == 1 || f3 == 5)) ? w[24:20] : 5'd0;
        if (opc == 'h13) begin
            if (f3 == 1)      legal = (f7 == 0);
            else if (f3 == 5) legal = (f7 == 0 || f7 == 'h20);
            else              legal = 1'b1;
            e.cls = legal ? 2'd0 : 2'd3;
        end else if (opc == 'h03) begin
            e.cls = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) ? 2'd1 : 2'd3;
        end else if (opc == 'h67) begin
            e.cls = (f3 == 0) ? 2'd2 : 2'd3;
        end else begin
            e.cls = 2'd3;
        end
        return e;
    endfunction

    function automatic logic [31:0] mk(input logic [11:0] imm, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd,
                                       input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    // Reference model state
    ent_t mq[$];
    int   mcnt  = 0;
    int   mlast = 0;
    bit   m_ir  = 1'b1;
    bit   m_acc = 1'b0;
    bit   m_pop;
    ent_t m_p;

    function automatic bit m_ov();
        return (mq.size() > 0) && !(mcnt != 0 && mlast != 0 && int'(mq[0].rs1) == mlast);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mcnt  = 0;
            mlast = 0;
            m_ir  = 1'b1;
            m_acc = 1'b0;
        end else begin
            m_acc = in_valid && m_ir && !flush;
            m_pop = m_ov() && out_ready && !flush;
            if (flush) begin
                mq.delete();
                mcnt = 0;
                m_ir = 1'b1;
            end else begin
                if (m_pop) begin
                    m_p = mq.pop_front();
                    if (m_p.cls == 2'd1) begin
                        mlast = int'(m_p.rd);
                        mcnt  = LU;
                    end else if (mcnt > 0) begin
                        mcnt--;
                    end
                end else if (mcnt > 0) begin
                    mcnt--;
                end
                if (m_acc) mq.push_back(mdec(in_instr));
                m_ir = (mq.size() < 2);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("cmp_out_valid", 32'(out_valid), 32'(m_ov()));
            chk("cmp_in_ready", 32'(in_ready), 32'(m_ir));
            if (m_ov()) begin
                chk("cmp_rd",      32'(out_rd),      32'(mq[0].rd));
                chk("cmp_rs1",     32'(out_rs1),     32'(mq[0].rs1));
                chk("cmp_funct3",  32'(out_funct3),  32'(mq[0].f3));
                chk("cmp_imm",     out_imm,          mq[0].imm);
                chk("cmp_shamt",   32'(out_shamt),   32'(mq[0].shamt));
                chk("cmp_class",   32'(out_class),   32'(mq[0].cls));
                chk("cmp_illegal", 32'(out_illegal), 32'(mq[0].cls == 2'd3));
            end
        end
    end

    // Log of rd values actually handed to execute
    logic [4:0] popped[$];
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready && !flush) popped.push_back(out_rd);
    end

    // Fetch side: present the head of fq until the model says it was taken
    logic [31:0] fq[$];

    task automatic tick();
        in_valid = (fq.size() > 0);
        if (fq.size() > 0) in_instr = fq[0];
        else               in_instr = 32'h0;
        @(posedge clk);
        #1;
        if (m_acc && fq.size() > 0) void'(fq.pop_front());
    endtask

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        out_ready = 1'b0;
        #1 rst = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_rd",        32'(out_rd),    32'd0);
        chk("rst_rs1",       32'(out_rs1),   32'd0);
        chk("rst_funct3",    32'(out_funct3), 32'd0);
        chk("rst_imm",       out_imm,        32'd0);
        chk("rst_shamt",     32'(out_shamt), 32'd0);
        chk("rst_class",     32'(out_class), 32'd0);
        chk("rst_illegal",   32'(out_illegal), 32'd0);
        rst = 1'b0;

        // Pin the reference decode against hand-decoded words
        chk("pin_addi_imm",  mdec(32'hFFF10093).imm, 32'hFFFFFFFF);
        chk("pin_srai_sh",   32'(mdec(32'h40525193).shamt), 32'd5);
        chk("pin_slli_ill",  32'(mdec(32'h02109093).cls), 32'd3);
        chk("pin_lw_cls",    32'(mdec(32'h00832283).cls), 32'd1);
        chk("pin_jalr_cls",  32'(mdec(32'h000100E7).cls), 32'd2);
        chk("pin_ld011_ill", 32'(mdec(mk(12'h0, 5'd1, 3'b011, 5'd2, 7'h03)).cls), 32'd3);

        // 1: addi x1,x2,-1
        out_ready = 1'b1;
        fq.push_back(32'hFFF10093);
        tick();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_rd",    32'(out_rd),    32'd1);
        chk("t1_rs1",   32'(out_rs1),   32'd2);
        chk("t1_imm",   out_imm,        32'hFFFFFFFF);
        chk("t1_class", 32'(out_class), 32'd0);
        tick();
        chk("t1_drain", 32'(out_valid), 32'd0);

        // 2: lw x5 then dependent addi -> one bubble
        fq.push_back(32'h00832283);
        fq.push_back(32'h00128393);
        tick();
        chk("t2_lw_valid", 32'(out_valid), 32'd1);
        chk("t2_lw_class", 32'(out_class), 32'd1);
        tick();
        chk("t2_bubble",   32'(out_valid), 32'd0);
        tick();
        chk("t2_issue",    32'(out_valid), 32'd1);
        chk("t2_issue_rd", 32'(out_rd),    32'd7);
        tick();
        // unrelated rs1 -> no bubble
        fq.push_back(32'h00832283);
        fq.push_back(32'h00130393);
        tick();
        tick();
        chk("t2_unrel", 32'(out_valid), 32'd1);
        tick();
        // load into x0, consumer reads x0 -> no bubble
        fq.push_back(32'h00832003);
        fq.push_back(32'h00100393);
        tick();
        tick();
        chk("t2_x0", 32'(out_valid), 32'd1);
        tick();

        // 3: srai legal shift, slli with bad funct7
        fq.push_back(32'h40525193);
        fq.push_back(32'h02109093);
        tick();
        chk("t3_shamt", 32'(out_shamt), 32'd5);
        chk("t3_class", 32'(out_class), 32'd0);
        chk("t3_rd",    32'(out_rd),    32'd3);
        chk("t3_imm",   out_imm,        32'h00000405);
        tick();
        chk("t3_ill_class", 32'(out_class),   32'd3);
        chk("t3_ill_flag",  32'(out_illegal), 32'd1);
        tick();
        // assorted legality corners, checked by the model
        fq.push_back(32'h000100E7);
        fq.push_back(mk(12'h0,   5'd1, 3'b011, 5'd2, 7'h03));
        fq.push_back(mk(12'h405, 5'd3, 3'b001, 5'd4, 7'h13));
        fq.push_back(mk(12'h205, 5'd3, 3'b101, 5'd4, 7'h13));
        fq.push_back(mk(12'h800, 5'd6, 3'b100, 5'd9, 7'h03));
        fq.push_back(mk(12'h001, 5'd9, 3'b000, 5'd10, 7'h13));
        fq.push_back(mk(12'h000, 5'd1, 3'b001, 5'd1, 7'h67));
        fq.push_back(32'h0000007F);
        for (int i = 0; i < 14; i++) tick();

        // 4: backpressure, three words, in-order release
        out_ready = 1'b0;
        popped.delete();
        fq.push_back(mk(12'h1, 5'd0, 3'b000, 5'd10, 7'h13));
        fq.push_back(mk(12'h2, 5'd0, 3'b000, 5'd11, 7'h13));
        fq.push_back(mk(12'h3, 5'd0, 3'b000, 5'd12, 7'h13));
        tick();
        chk("t4_ready_one", 32'(in_ready), 32'd1);
        tick();
        chk("t4_full",      32'(in_ready), 32'd0);
        tick();
        chk("t4_hold_rd",   32'(out_rd),   32'd10);
        chk("t4_still_full", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("t4_pop_count", 32'(popped.size()), 32'd3);
        if (popped.size() == 3) begin
            chk("t4_pop0", 32'(popped[0]), 32'd10);
            chk("t4_pop1", 32'(popped[1]), 32'd11);
            chk("t4_pop2", 32'(popped[2]), 32'd12);
        end

        // 5: flush while FULL with an incoming word
        out_ready = 1'b0;
        fq.push_back(mk(12'h1, 5'd0, 3'b000, 5'd13, 7'h13));
        fq.push_back(mk(12'h1, 5'd0, 3'b000, 5'd14, 7'h13));
        tick();
        tick();
        chk("t5_full_valid", 32'(out_valid), 32'd1);
        fq.push_back(mk(12'h1, 5'd0, 3'b000, 5'd15, 7'h13));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_ready", 32'(in_ready),  32'd1);
        fq.delete();
        out_ready = 1'b1;
        popped.delete();
        tick();
        tick();
        chk("t5_no_output", 32'(popped.size()), 32'd0);

        // 6: async reset while FULL after a load has retired
        fq.push_back(32'h00832283);
        tick();
        tick();
        out_ready = 1'b0;
        fq.push_back(32'h00128393);
        fq.push_back(mk(12'h1, 5'd5, 3'b000, 5'd8, 7'h13));
        tick();
        tick();
        chk("t6_full_valid", 32'(out_valid), 32'd1);
        fq.delete();
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_ready", 32'(in_ready),  32'd1);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        fq.push_back(mk(12'h1, 5'd5, 3'b000, 5'd9, 7'h13));
        tick();
        chk("t6_first_valid", 32'(out_valid), 32'd1);
        chk("t6_first_rd",    32'(out_rd),    32'd9);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_i_type_decode_stage
`default_nettype wire
